audio_serial_slave: RTL and testbench
=====================================

# audio_serial_slave

Codec-side endpoint of the board audio serial link: receives BCLK and LRCK from the FPGA-side codec master, deserializes DAC data into 16-bit words tagged by channel, and serializes ADC words back on the ADC data line. Used as the bit-accurate codec model in the audio datapath benches. It also serves as the FPGA-side slave when an external device owns the audio clocks. All logic runs on the system `clk`; link pins are oversampled.

## Interface
- `DATA_WIDTH`, default 16: bits per channel word, legal 8..32.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `AUD_BCLK` in 1: bit clock from master, asynchronous to `clk`.
- `AUD_LRCK` in 1: frame clock from master; high = left, low = right.
- `AUD_DACDAT` in 1: serial data from master (received here).
- `AUD_ADCDAT` out 1: serial data to master (transmitted here).
- `rx_data` out DATA_WIDTH: last completed received word.
- `rx_left` out 1: channel of `rx_data`; 1 = left.
- `rx_valid` out 1: one-cycle pulse when `rx_data`/`rx_left` update.
- `rx_short` out 1: one-cycle pulse when a channel slot ended before DATA_WIDTH bits arrived.
- `tx_left`, `tx_right` in DATA_WIDTH: stereo pair to transmit.
- `tx_valid` in 1: pair offered.
- `tx_ready` out 1: holding register empty; pair accepted when `tx_valid & tx_ready`.
- `tx_underrun` out 1: one-cycle pulse when a left slot starts with no pair held.

## Operation
- Input sync: `AUD_BCLK`, `AUD_LRCK`, `AUD_DACDAT` each pass 2 flops; a third flop on BCLK/LRCK gives edge detect. All decisions use synchronized values.
- Format: left-justified, MSB first. An LRCK edge starts a slot; MSB is valid from the edge. Master shifts on BCLK falling and samples on BCLK rising.
- States: WARMUP (3 cycles after reset release; edges ignored) -> IDLE (wait for first LRCK edge of either polarity) -> RUN. RUN is left only by reset.
- In WARMUP/IDLE: `AUD_ADCDAT`=0, no `rx_valid`/`rx_short`, no pair consumed, no `tx_underrun`. Loads into the holding register are allowed.
- Receive (RUN): a bit counter clears on each LRCK edge. On each BCLK rising edge with count < DATA_WIDTH, shift in DACDAT MSB-first and increment. At count reaching DATA_WIDTH, publish `rx_data`, set `rx_left` to the current LRCK, and pulse `rx_valid`. Extra bits in the slot are ignored.
- Short slot: an LRCK edge with 0 < count < DATA_WIDTH pulses `rx_short`. The partial word is discarded and `rx_data` is unchanged.
- Transmit, left start (LRCK rising, RUN): if the holding register is full, `tx_left` goes to the shifter, `tx_right` to the right buffer, and the holding register empties. Otherwise the shifter and right buffer load 0 and `tx_underrun` pulses.
- Transmit, right start (LRCK falling, RUN): the shifter loads the right buffer.
- `AUD_ADCDAT` = shifter MSB. Each BCLK falling edge shifts left, filling with 0. Bits after DATA_WIDTH are 0.
- An LRCK edge coinciding with a BCLK falling edge, in the same synchronized cycle, loads the shifter and does not shift.
- First RUN slot: if it is a right slot, it transmits the reset-zero right buffer and does not flag underrun.
- Holding register: loaded on `tx_valid & tx_ready`. If a load and a left start happen in the same cycle with the register empty, the result is underrun. The loaded pair is kept for the next left start.

## Timing
- Reset values: `AUD_ADCDAT`=0, `rx_data`=0, `rx_left`=0, `rx_valid`=0, `rx_short`=0, `tx_underrun`=0, `tx_ready`=1; state WARMUP.
- Pin-to-action latency is 3 `clk` cycles (2 sync + edge register). `AUD_ADCDAT` changes on the 3rd `clk` edge after the BCLK/LRCK pin edge.
- Requirement: BCLK high and low phases each ≥ 4 `clk` periods. This lets ADCDAT settle before the master samples on the next rising edge.
- `rx_valid` asserts 3 cycles after the pin BCLK rising edge that carried the last bit.
- `tx_ready` falls the cycle after acceptance and rises the cycle after consumption.
- Reset mid-slot: everything clears immediately. The block returns through WARMUP/IDLE; the interrupted partial word is not reported as short.

## Test plan
- Master at BCLK = clk/8, LRCK = clk/256, DACDAT left=16'hA5C3, right=16'h0F0F -> `rx_valid` twice per frame: `rx_data`=A5C3 with `rx_left`=1, then 0F0F with `rx_left`=0; no `rx_short`.
- Pair (16'h8001, 16'h7FFE) preloaded before a left start -> master captures 8001 left and 7FFE right; `tx_ready` low for one frame, then high.
- No pair offered at a left start -> `tx_underrun` pulses once; master captures 0000 on both channels.
- LRCK toggles after 10 BCLK cycles -> `rx_short` pulses; `rx_data` holds its previous value; next full slot decodes correctly.
- `tx_valid` asserted in the exact left-start cycle with the holding register empty -> underrun for that frame; the pair is transmitted on the next frame.
- `reset` asserted mid-left-slot, released with LRCK high -> no outputs until the next LRCK edge; the following frame decodes and transmits correctly.

Source files
------------

// File: rtl/audio_serial_slave.sv
// ---------------------------------------------------------------------------
// audio_serial_slave
//
// Codec-side endpoint of a left-justified, MSB-first audio serial link.
// BCLK/LRCK come from an external master and are oversampled on clk. DAC
// data is deserialized into channel-tagged words; ADC words are serialized
// back out, one stereo pair per frame, from a single-entry holding register.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        asynchronous, active-high
//   AUD_BCLK     bit clock from master (async to clk)
//   AUD_LRCK     frame clock from master, 1 = left slot
//   AUD_DACDAT   serial data from master
//   AUD_ADCDAT   serial data to master
//   rx_data      last completed received word
//   rx_left      channel of rx_data, 1 = left
//   rx_valid     one-cycle pulse when rx_data/rx_left update
//   rx_short     one-cycle pulse when a slot ended before DATA_WIDTH bits
//   tx_left      left word of the pair to transmit
//   tx_right     right word of the pair to transmit
//   tx_valid     pair offered
//   tx_ready     holding register empty
//   tx_underrun  one-cycle pulse when a left slot starts with no pair held
// ---------------------------------------------------------------------------
module audio_serial_slave #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_LRCK,
    input  logic                  AUD_DACDAT,
    output logic                  AUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_left,
    output logic                  rx_valid,
    output logic                  rx_short,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WARMUP,
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;
    logic [1:0] warm_cnt;

    // [0],[1] synchronize; [2] is the previous synchronized value for edges
    logic [2:0] bclk_sync;
    logic [2:0] lrck_sync;
    logic [1:0] dac_sync;

    logic bclk_rise, bclk_fall, lrck_rise, lrck_fall, lrck_edge;
    logic left_start, right_start;

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] right_buf;
    logic [DATA_WIDTH-1:0] hold_left;
    logic [DATA_WIDTH-1:0] hold_right;
    logic                  hold_full;

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign bclk_fall = ~bclk_sync[1] & bclk_sync[2];
    assign lrck_rise = lrck_sync[1] & ~lrck_sync[2];
    assign lrck_fall = ~lrck_sync[1] & lrck_sync[2];
    assign lrck_edge = lrck_rise | lrck_fall;

    // The LRCK edge that moves IDLE to RUN already opens the first RUN slot.
    assign left_start  = lrck_rise & (state != WARMUP);
    assign right_start = lrck_fall & (state != WARMUP);

    assign AUD_ADCDAT = tx_shift[DATA_WIDTH-1];
    assign tx_ready   = ~hold_full;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dac_sync  <= '0;
            state     <= WARMUP;
            warm_cnt  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[1:0], AUD_LRCK};
            dac_sync  <= {dac_sync[0], AUD_DACDAT};
            state     <= state_next;
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    // NOTE: next-state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            WARMUP:  if (warm_cnt == 2'd2) state_next = IDLE;
            IDLE:    if (lrck_edge) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = WARMUP;
        endcase
    end

    // Receive path
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_left  <= 1'b0;
            rx_valid <= 1'b0;
            rx_short <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_short <= 1'b0;
            if (lrck_edge && state != WARMUP) begin
                // bit_cnt is always zero in IDLE, so only RUN can flag short
                if (bit_cnt != '0 && bit_cnt < CW'(DATA_WIDTH)) begin
                    rx_short <= 1'b1;
                end
                bit_cnt <= '0;
            end else if (state == RUN && bclk_rise && bit_cnt < CW'(DATA_WIDTH)) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], dac_sync[1]};
                bit_cnt  <= bit_cnt + CW'(1);
                if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    rx_data  <= {rx_shift[DATA_WIDTH-2:0], dac_sync[1]};
                    rx_left  <= lrck_sync[1];
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // Transmit path and holding register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift    <= '0;
            right_buf   <= '0;
            hold_left   <= '0;
            hold_right  <= '0;
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;

            // A slot start reloads the shifter and wins over a coincident
            // BCLK falling edge, so the MSB is never shifted away.
            if (left_start) begin
                if (hold_full) begin
                    tx_shift  <= hold_left;
                    right_buf <= hold_right;
                end else begin
                    tx_shift    <= '0;
                    right_buf   <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (right_start) begin
                tx_shift <= right_buf;
            end else if (state == RUN && bclk_fall) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            // Load needs empty, consume needs full: never both in one cycle.
            // A load coinciding with a left start therefore waits a frame.
            if (tx_valid && !hold_full) begin
                hold_full  <= 1'b1;
                hold_left  <= tx_left;
                hold_right <= tx_right;
            end else if (left_start && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_serial_slave.sv
// ---------------------------------------------------------------------------
// tb_audio_serial_slave
//
// Directed bench: models the link master at BCLK = clk/8, LRCK = clk/256
// (16 BCLK per slot). Pins change on clk falling edges; the master captures
// AUD_ADCDAT at each BCLK rising edge. A monitor logs rx_valid words and
// counts rx_short / tx_underrun pulses.
// ---------------------------------------------------------------------------
module tb_audio_serial_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        AUD_BCLK, AUD_LRCK, AUD_DACDAT, AUD_ADCDAT;
    logic [15:0] rx_data;
    logic        rx_left, rx_valid, rx_short;
    logic [15:0] tx_left, tx_right;
    logic        tx_valid, tx_ready, tx_underrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] rxq[$];
    int          n_short    = 0;
    int          n_underrun = 0;
    logic [15:0] short_data = '0;

    audio_serial_slave #(.DATA_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_LRCK    (AUD_LRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .AUD_ADCDAT  (AUD_ADCDAT),
        .rx_data     (rx_data),
        .rx_left     (rx_left),
        .rx_valid    (rx_valid),
        .rx_short    (rx_short),
        .tx_left     (tx_left),
        .tx_right    (tx_right),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rxq.push_back({rx_left, rx_data});
        if (rx_short) begin
            n_short    = n_short + 1;
            short_data = rx_data;
        end
        if (tx_underrun) n_underrun = n_underrun + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One BCLK period starting at a falling edge; called on a clk negedge.
    task automatic bit_cycle(input logic lrck, input logic d, input logic offer,
                             output logic cap);
        AUD_BCLK   = 1'b0;
        AUD_LRCK   = lrck;
        AUD_DACDAT = d;
        if (offer) begin
            // tx_valid lands on the clk edge that acts on this LRCK edge
            repeat (2) @(negedge clk);
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        AUD_BCLK = 1'b1;
        cap      = AUD_ADCDAT;
        repeat (4) @(negedge clk);
    endtask

    task automatic slot(input logic lrck, input logic [15:0] w, input int nbits,
                        input logic offer, output logic [15:0] cap);
        logic c;
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            bit_cycle(lrck, (i < 16) ? w[15-i] : 1'b0, offer && (i == 0), c);
            if (i < 16) cap[15-i] = c;
        end
    endtask

    task automatic offer_pair(input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("offer_ready", tx_ready, 1);
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [15:0] d, input logic l);
        logic [16:0] e;
        check({tag, "_present"}, rxq.size() != 0, 1);
        if (rxq.size() != 0) begin
            e = rxq.pop_front();
            check({tag, "_data"}, e[15:0], d);
            check({tag, "_left"}, e[16], l);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cl, cr;
        logic        c;
        logic [9:0]  post;

        reset      = 1'b1;
        AUD_BCLK   = 1'b0;
        AUD_LRCK   = 1'b1;
        AUD_DACDAT = 1'b0;
        tx_left    = '0;
        tx_right   = '0;
        tx_valid   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_adcdat",   AUD_ADCDAT, 0);
        check("rst_rx_data",  rx_data, 0);
        check("rst_rx_left",  rx_left, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_short", rx_short, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_tx_ready", tx_ready, 1);

        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Preload a pair; first RUN slot is right and sends the zero buffer
        offer_pair(16'h8001, 16'h7FFE);
        @(negedge clk);
        check("preload_ready_low", tx_ready, 0);
        slot(1'b0, 16'h0F0F, 16, 1'b0, cr);
        check("first_right_tx", cr, 16'h0000);
        pop_rx("first_right_rx", 16'h0F0F, 1'b0);

        // Full frame using the preloaded pair
        slot(1'b1, 16'hA5C3, 16, 1'b0, cl);
        slot(1'b0, 16'h0F0F, 16, 1'b0, cr);
        check("frameA_tx_left",  cl, 16'h8001);
        check("frameA_tx_right", cr, 16'h7FFE);
        pop_rx("frameA_rx_l", 16'hA5C3, 1'b1);
        pop_rx("frameA_rx_r", 16'h0F0F, 1'b0);
        check("frameA_ready",    tx_ready, 1);
        check("frameA_underrun", n_underrun, 0);
        check("frameA_short",    n_short, 0);

        // No pair offered: underrun, zeros on both channels
        slot(1'b1, 16'h1234, 16, 1'b0, cl);
        slot(1'b0, 16'h5678, 16, 1'b0, cr);
        check("under_tx_left",  cl, 16'h0000);
        check("under_tx_right", cr, 16'h0000);
        check("under_count",    n_underrun, 1);
        pop_rx("under_rx_l", 16'h1234, 1'b1);
        pop_rx("under_rx_r", 16'h5678, 1'b0);

        // Short left slot of 10 bits, then a full right slot
        slot(1'b1, 16'hFFFF, 10, 1'b0, cl);
        slot(1'b0, 16'h3C5A, 16, 1'b0, cr);
        check("short_count", n_short, 1);
        check("short_held",  short_data, 16'h5678);
        pop_rx("short_next_rx", 16'h3C5A, 1'b0);
        check("short_no_extra", rxq.size(), 0);
        check("short_underrun", n_underrun, 2);

        // Pair offered in the exact left-start cycle: underrun this frame
        tx_left  = 16'hCAFE;
        tx_right = 16'hBEEF;
        slot(1'b1, 16'h9999, 16, 1'b1, cl);
        check("race_ready_low", tx_ready, 0);
        slot(1'b0, 16'h6666, 16, 1'b0, cr);
        check("race_tx_left",  cl, 16'h0000);
        check("race_tx_right", cr, 16'h0000);
        check("race_underrun", n_underrun, 3);
        slot(1'b1, 16'hAAAA, 16, 1'b0, cl);
        slot(1'b0, 16'h5555, 16, 1'b0, cr);
        check("race_next_left",  cl, 16'hCAFE);
        check("race_next_right", cr, 16'hBEEF);
        check("race_next_underrun", n_underrun, 3);
        pop_rx("race_rx0", 16'h9999, 1'b1);
        pop_rx("race_rx1", 16'h6666, 1'b0);
        pop_rx("race_rx2", 16'hAAAA, 1'b1);
        pop_rx("race_rx3", 16'h5555, 1'b0);

        // Reset in the middle of a left slot, LRCK held high
        offer_pair(16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 6; i++) begin
            bit_cycle(1'b1, 1'b1, 1'b0, c);
            if (i == 2) offer_pair(16'h1111, 16'h2222);
        end
        check("pre_rst_ready",  tx_ready, 0);
        check("pre_rst_adcdat", AUD_ADCDAT, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_adcdat",  AUD_ADCDAT, 0);
        check("mid_rst_rx_data", rx_data, 0);
        check("mid_rst_ready",   tx_ready, 1);
        reset = 1'b0;
        post = '1;
        for (int i = 0; i < 10; i++) begin
            bit_cycle(1'b1, 1'b1, 1'b0, c);
            post[i] = c;
        end
        check("post_rst_adcdat", post, 0);
        check("post_rst_no_rx",  rxq.size(), 0);
        check("post_rst_short",  n_short, 1);

        offer_pair(16'h2468, 16'h1357);
        slot(1'b0, 16'h0F0F, 16, 1'b0, cr);
        check("post_rst_first_right", cr, 16'h0000);
        slot(1'b1, 16'h4242, 16, 1'b0, cl);
        slot(1'b0, 16'h2424, 16, 1'b0, cr);
        check("post_rst_tx_left",  cl, 16'h2468);
        check("post_rst_tx_right", cr, 16'h1357);
        pop_rx("post_rst_rx0", 16'h0F0F, 1'b0);
        pop_rx("post_rst_rx1", 16'h4242, 1'b1);
        pop_rx("post_rst_rx2", 16'h2424, 1'b0);
        check("post_rst_short_final", n_short, 1);
        check("post_rst_underrun",    n_underrun, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
